// File: rtl/boid_frame_rasterizer.sv
// boid_frame_rasterizer: sweeps one frame in raster order, issues x/y pixel checks,
// realigns the returned is_boid_here with its pixel and writes one colour per pixel.
// Ports:
//   clk, reset (sync, active-high), start (one-cycle frame request)
//   x, y            check coordinates, col/row in fixed point with FRAC_BITS fraction bits
//   is_boid_here    check result for the x/y issued CHK_LAT cycles earlier
//   wr_en, wr_addr, wr_data  framebuffer write port (address = row*H_RES + col)
//   busy            high from the start-accept cycle through the DONE cycle
//   frame_done      one-cycle pulse after the last pixel write
// Optional macro BOID_RAST_BORDER_EN: frame-edge pixels are written with BORDER_COLOR.
module boid_frame_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int ADDR_W = 19,
    parameter int COLOR_W = 8,
    parameter int FRAC_BITS = 16,
    parameter int CHK_LAT = 1,
    parameter logic [COLOR_W-1:0] BOID_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00
`ifdef BOID_RAST_BORDER_EN
    ,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 8'h1C
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [31:0]        x,
    output logic [31:0]        y,
    input  logic               is_boid_here,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               frame_done
);
    localparam int CW = H_RES > 1 ? $clog2(H_RES) : 1;
    localparam int RW = V_RES > 1 ? $clog2(V_RES) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_RES - 1);
`ifdef BOID_RAST_BORDER_EN
    localparam int EW = ADDR_W + 1;
`else
    localparam int EW = ADDR_W;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    logic              issue, hold, col_end, last_pix;
    logic              o_v;
    logic [EW-1:0]     e_in, e_out;
    logic [COLOR_W-1:0] px_color;

    assign issue    = state_q == SCAN;
    assign col_end  = col_q == COL_MAX;
    assign last_pix = col_end && row_q == ROW_MAX;
    // Counters freeze on the last pixel so DRAIN keeps presenting it on x/y.
    assign hold     = state_q == DRAIN || (issue && last_pix);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_pix) state_d = (CHK_LAT > 0) ? DRAIN : DONE;
            DRAIN:   if (drain_q == 3'(CHK_LAT - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d   = hold ? col_q : issue ? (col_end ? '0 : col_q + 1'b1) : '0;
        row_d   = hold ? row_q : issue ? (col_end ? row_q + 1'b1 : row_q) : '0;
        addr_d  = hold ? addr_q : issue ? addr_q + 1'b1 : '0;
        drain_d = state_q == DRAIN ? drain_q + 1'b1 : '0;
    end

`ifdef BOID_RAST_BORDER_EN
    assign e_in = {col_q == '0 || col_end || row_q == '0 || row_q == ROW_MAX, addr_q};
`else
    assign e_in = addr_q;
`endif

    // Delay line aligning each issued pixel with its check result.
    generate
        if (CHK_LAT == 0) begin : g_pass
            assign o_v   = issue;
            assign e_out = e_in;
        end else begin : g_dl
            logic [CHK_LAT-1:0] v_q, v_d;
            logic [EW-1:0]      e_q [CHK_LAT];
            logic [EW-1:0]      e_d [CHK_LAT];
            always_comb begin
                v_d[0] = issue;
                e_d[0] = e_in;
                for (int i = 1; i < CHK_LAT; i++) begin
                    v_d[i] = v_q[i-1];
                    e_d[i] = e_q[i-1];
                end
            end
            always_ff @(posedge clk) begin
                if (reset) v_q <= '0;
                else v_q <= v_d;
                e_q <= e_d;
            end
            assign o_v   = v_q[CHK_LAT-1];
            assign e_out = e_q[CHK_LAT-1];
        end
    endgenerate

`ifdef BOID_RAST_BORDER_EN
    assign px_color = e_out[ADDR_W] ? BORDER_COLOR : is_boid_here ? BOID_COLOR : BG_COLOR;
`else
    assign px_color = is_boid_here ? BOID_COLOR : BG_COLOR;
`endif

    always_comb begin
        busy       = state_q != IDLE;
        frame_done = state_q == DONE;
        x          = (issue || state_q == DRAIN) ? 32'(col_q) << FRAC_BITS : '0;
        y          = (issue || state_q == DRAIN) ? 32'(row_q) << FRAC_BITS : '0;
        wr_en      = o_v;
        wr_addr    = o_v ? e_out[ADDR_W-1:0] : '0;
        wr_data    = o_v ? px_color : BG_COLOR;
    end
endmodule

// File: tb/tb_boid_frame_rasterizer.sv
// tb_boid_frame_rasterizer: three rasterizers (CHK_LAT 0/1/3) on a 4x3 frame against a frame-level model.
module tb_boid_frame_rasterizer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;
    localparam int DONE_AT [3] = '{12, 13, 15};
    localparam int RST_W [3] = '{9, 8, 6};
    localparam int RST_LA [3] = '{8, 7, 5};

    logic clk = 0;
    logic rst = 1;
    logic start = 0;
    logic junk = 0;
    logic [N-1:0] map = '0;
    always #5 clk = ~clk;

    logic [31:0] x_a [3];
    logic [31:0] y_a [3];
    logic        we_a [3];
    logic [18:0] wa_a [3];
    logic [7:0]  wd_a [3];
    logic        busy_a [3];
    logic        fd_a [3];
    logic        ib [3];

    bit  active [3];
    int  k [3];
    bit  ewe [3];
    int  cyc = 0;
    int  scan_cyc = 0;
    bit  chk_en = 0, clr = 1, lit1 = 0, lit2 = 0, tmo = 0;
    int  checks = 0, fails = 0;
    int  wc [3], ffc [3], ffa [3], dc [3], doff [3], la [3];

    function automatic int lat(int i);
        return i == 0 ? 0 : i == 1 ? 1 : 3;
    endfunction

    function automatic int pix(logic [31:0] xx, logic [31:0] yy);
        int p;
        p = int'(yy >> 16) * H + int'(xx >> 16);
        return (p >= 0 && p < N) ? p : 0;
    endfunction

    function automatic void check(string nm, int i, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s [lat=%0d] got %0h want %0h at %0t", nm, lat(i), act, exp, $time);
        end
    endfunction

    always_comb
        for (int i = 0; i < 3; i++)
            ewe[i] = active[i] && k[i] >= lat(i) && k[i] < N + lat(i);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        boid_frame_rasterizer #(.H_RES(H), .V_RES(V), .CHK_LAT(L)) dut (
            .clk(clk), .reset(rst), .start(start), .x(x_a[g]), .y(y_a[g]),
            .is_boid_here(ib[g]), .wr_en(we_a[g]), .wr_addr(wa_a[g]), .wr_data(wd_a[g]),
            .busy(busy_a[g]), .frame_done(fd_a[g])
        );
        // Checker model: answers from the boid map for the coordinates seen L cycles ago.
        if (L == 0) begin : g_l0
            assign ib[g] = ewe[g] ? map[pix(x_a[g], y_a[g])] : junk;
        end else begin : g_ln
            int hist [L];
            always @(posedge clk) begin
                hist[0] <= pix(x_a[g], y_a[g]);
                for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
            end
            assign ib[g] = ewe[g] ? map[hist[L-1]] : junk;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: k counts cycles since the first SCAN cycle; frame lasts N+LAT+1 cycles.
    always @(posedge clk)
        for (int i = 0; i < 3; i++) begin
            if (rst) active[i] <= 0;
            else if (!active[i]) begin
                if (start) begin
                    active[i] <= 1;
                    k[i] <= 0;
                end
            end else begin
                if (k[i] == N + lat(i)) active[i] <= 0;
                k[i] <= k[i] + 1;
            end
        end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (tmo) begin
                checks++;
                fails++;
                $display("FAIL timeout waiting for idle at %0t", $time);
            end
            for (int i = 0; i < 3; i++) begin
                int L, kk, ea, p;
                logic [7:0] ed;
                L  = lat(i);
                kk = k[i];
                ea = ewe[i] ? kk - L : 0;
                ed = ewe[i] ? (map[ea] ? 8'hFF : 8'h00) : 8'h00;
                check("busy", i, busy_a[i], active[i]);
                check("frame_done", i, fd_a[i], active[i] && kk == N + L);
                check("wr_en", i, we_a[i], ewe[i]);
                check("wr_addr", i, wa_a[i], ea);
                check("wr_data", i, wd_a[i], ed);
                if (!active[i] || kk < N + L) begin
                    p = kk < N ? kk : N - 1;
                    check("x", i, x_a[i], active[i] ? (p % H) << 16 : 0);
                    check("y", i, y_a[i], active[i] ? (p / H) << 16 : 0);
                end
                if (lit1) begin
                    check("f1_writes", i, wc[i], 12);
                    check("f1_boid_writes", i, ffc[i], 1);
                    check("f1_boid_addr", i, ffa[i], 6);
                    check("f1_done_count", i, dc[i], 1);
                    check("f1_done_at", i, doff[i], DONE_AT[i]);
                end
                if (lit2) begin
                    check("rst_writes", i, wc[i], RST_W[i]);
                    check("rst_last_addr", i, la[i], RST_LA[i]);
                    check("rst_done_count", i, dc[i], 0);
                end
                if (clr) begin
                    wc[i] = 0; ffc[i] = 0; ffa[i] = -1; dc[i] = 0; doff[i] = -1; la[i] = -1;
                end else begin
                    if (we_a[i]) begin
                        wc[i]++;
                        la[i] = int'(wa_a[i]);
                        if (wd_a[i] == 8'hFF) begin
                            ffc[i]++;
                            ffa[i] = int'(wa_a[i]);
                        end
                    end
                    if (fd_a[i]) begin
                        dc[i]++;
                        doff[i] = cyc - scan_cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        junk = 1'($urandom);
    endtask

    task automatic launch();
        start = 1;
        scan_cyc = cyc + 1;
        tick();
        start = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a[0] | busy_a[1] | busy_a[2]) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            tmo = 1;
            tick();
            tmo = 0;
        end
    endtask

    task automatic pulse_lit(int which);
        if (which == 1) lit1 = 1; else lit2 = 1;
        tick();
        lit1 = 0;
        lit2 = 0;
    endtask

    task automatic new_frame(logic [N-1:0] m);
        clr = 1;
        map = m;
        tick();
        clr = 0;
    endtask

    initial begin
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        repeat (5) tick();
        // Single boid at col 2, row 1 -> address 6.
        new_frame(12'h040);
        launch();
        wait_idle();
        pulse_lit(1);
        // Starts during SCAN, in lat=1's DONE cycle, then the following IDLE cycle.
        new_frame(N'($urandom));
        launch();
        repeat (5) tick();
        start = 1; tick(); start = 0;
        repeat (7) tick();
        start = 1; tick();
        start = 1; tick(); start = 0;
        wait_idle();
        // Reset mid-frame after lat=1 writes address 7.
        new_frame(N'($urandom));
        launch();
        repeat (8) tick();
        rst = 1; tick(); rst = 0;
        repeat (3) tick();
        pulse_lit(2);
        for (int f = 0; f < 6; f++) begin
            new_frame(N'($urandom));
            launch();
            for (int c = 0; c < 20; c++) begin
                start = ($urandom % 6) == 0;
                rst = ($urandom % 50) == 0;
                tick();
            end
            start = 0;
            rst = 0;
            wait_idle();
            repeat ($urandom_range(1, 4)) tick();
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/boid_frame_rasterizer.md
Name: boid_frame_rasterizer

Overview:
Downstream consumer of the boid accelerator's pixel check. It sweeps every pixel of one frame in raster order and drives the x/y check coordinates. It pipelines the returned is_boid_here against the issued coordinates and writes one colour word per pixel into the VGA M10K framebuffer write port. One frame is produced per start pulse, followed by a frame_done pulse that the top level uses to enable the next boid update.

Parameters:
H_RES, 640, pixels per line
V_RES, 480, lines per frame
ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
COLOR_W, 8, framebuffer data width
FRAC_BITS, 16, fractional bits of the 32-bit check coordinate format
CHK_LAT, 1, cycles from x/y valid to matching is_boid_here valid; range 0..4
BOID_COLOR, 8'hFF, colour written where is_boid_here=1
BG_COLOR, 8'h00, colour written elsewhere

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to rasterize a frame
x  out  32  check column = col << FRAC_BITS, zero-extended
y  out  32  check row = row << FRAC_BITS, zero-extended
is_boid_here  in  1  check result for the x/y driven CHK_LAT cycles earlier
wr_en  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  framebuffer address = row*H_RES + col
wr_data  out  COLOR_W  pixel colour
busy  out  1  high from the start-accept cycle through the DONE cycle
frame_done  out  1  one-cycle pulse after the last pixel write

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, col=0, row=0, linear address=0, delay line valid bits cleared, wr_en=0, wr_addr=0, wr_data=BG_COLOR, busy=0, frame_done=0, x=0, y=0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: x=y=0. When start=1, go to SCAN and set busy=1 on the next edge.
- SCAN: one pixel is issued per cycle. x/y reflect the current col/row, and {col,row,addr,valid=1} enter a CHK_LAT-deep delay line.
  - col increments every cycle. At col=H_RES-1, col wraps to 0 and row increments.
  - The linear address increments by 1 every cycle; no multiplier is used.
  - After issuing col=H_RES-1, row=V_RES-1, go to DRAIN if CHK_LAT>0, else DONE.
- DRAIN: x/y hold the last pixel. Invalid bubbles are shifted in. Stay for exactly CHK_LAT cycles, then go to DONE.
- Write stage: when the delay-line output is valid, drive wr_en=1, wr_addr=delayed addr, and wr_data = is_boid_here ? BOID_COLOR : BG_COLOR, combinationally from the delay-line output in the same cycle.
  - When the output is invalid, wr_en=0.
  - With CHK_LAT=0 the delay line is a pass-through and the write occurs in the issue cycle.
- DONE: frame_done=1 for exactly one cycle; busy remains 1 in this cycle; next state is IDLE.
- Totals: exactly H_RES*V_RES writes per frame, with strictly increasing addresses 0..H_RES*V_RES-1.
- Latency: first write CHK_LAT cycles after the first SCAN cycle; frame_done H_RES*V_RES+CHK_LAT cycles after the first SCAN cycle.
- start while busy=1 is ignored and not queued.
- start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- reset mid-frame: the next cycle is IDLE with all outputs at reset values. In-flight delay-line entries are discarded, and no write or frame_done follows.
- is_boid_here is sampled only when the delay-line output is valid; it is ignored otherwise.

Optional Feature:
Macro BOID_RAST_BORDER_EN.
- Defined: adds parameter BORDER_COLOR (default 8'h1C). Pixels with col=0, col=H_RES-1, row=0 or row=V_RES-1 are written with BORDER_COLOR regardless of is_boid_here. The border flag is carried in the delay line.
- Undefined: border pixels follow the normal boid/background rule; there is no BORDER_COLOR parameter and no extra delay-line bit.

Test Plan:
- Reset and idle: H_RES=4, V_RES=3, CHK_LAT=1, reset for 2 cycles, no start -> wr_en=0, busy=0, frame_done=0, x=y=0 throughout.
- Full frame, background only: same parameters, start pulse, is_boid_here=0 -> exactly 12 writes, addr 0..11 consecutive, all data 8'h00; frame_done single pulse 13 cycles after the first SCAN cycle; busy falls the cycle after.
- Alignment: same parameters, checker model returns 1 only for x=2<<16, y=1<<16, delayed by CHK_LAT -> only the write to addr 6 carries 8'hFF. Repeat with CHK_LAT=0 and CHK_LAT=3: same addr/data, and frame_done at 12 and 15 cycles respectively.
- Start during frame: second start pulses at SCAN cycle 5 and in the DONE cycle -> still 12 writes and one frame_done; start 1 cycle later in IDLE -> second frame begins at addr 0.
- Reset mid-frame: assert reset after write addr=7 -> next cycle wr_en=0, no further writes, no frame_done; a new start writes addr 0..11.
- BOID_RAST_BORDER_EN defined, H_RES=4, V_RES=3, is_boid_here=1 everywhere -> addrs 0-4 and 7-11 written 8'h1C, addrs 5 and 6 written 8'hFF.
